uart_send: RTL and testbench
============================

Name: uart_send

Overview:
UART transmitter: serialises bytes onto uart_txd as 8N1 frames (LSB first) at UART_BPS, derived from sys_clk.
- Companion to the UART receive path in the uart_fifo subsystem; the TX side of the same link.
- Fed by the FIFO read side through a valid/ready handshake.
- Has a one-byte holding register so consecutive bytes go out back-to-back with no idle gap.

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz
UART_BPS, 9600, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division) = cycles per bit, must be 2..65535
STOP_BITS, 1, number of stop bits, legal values 1 or 2

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  asynchronous active-high reset
tx_valid  input  1  byte on tx_data is offered
tx_data  input  8  byte to transmit
tx_ready  output  1  holding register empty; byte accepted when tx_valid & tx_ready on a rising edge
tx_busy  output  1  a frame is on the line (state != IDLE)
tx_done  output  1  one-cycle pulse, last cycle of final stop bit
uart_txd  output  1  serial line, idle high

Behaviour:
- Interface: one clock (sys_clk); reset (sys_rst) asynchronous, active-high.
- Reset: uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit counter=0, holding register empty (data 0).
- Everything is registered; uart_txd is driven from a flop (glitch-free).
- Holding register (hold_data, hold_full):
  - Set on accept.
  - Cleared when the FSM loads from it.
  - tx_ready = ~hold_full, registered.
  - Accept and load in the same cycle cannot occur: tx_ready is 0 while full. After a load, tx_ready rises on the next cycle.
- tx_data is sampled only on the accept edge. Later changes to tx_data have no effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1. If hold_full, load shift register, clear hold_full, go to START. The first start-bit cycle is the cycle after the load.
  - Latency: accept edge at cycle N with FSM idle, hold loaded N+1, uart_txd=0 from N+2.
  - START: uart_txd=0 for BPS_CNT cycles, then DATA.
  - DATA: 8 bits, bit 0 first, each BPS_CNT cycles. A 3-bit counter selects the bit and wraps 7->0 on leaving DATA.
  - STOP: uart_txd=1 for STOP_BITS*BPS_CNT cycles. On the final cycle, tx_done=1. If hold_full, load and go to START so the start bit follows immediately (no idle cycle). Otherwise go to IDLE.
- Baud counter: 16 bits, counts 0..BPS_CNT-1, resets to 0 on every state change. Each bit lasts exactly BPS_CNT cycles.
- tx_busy=1 in START/DATA/STOP.
- tx_valid while tx_ready=0 is ignored; no data loss is required of the sender.
- Reset mid-frame: line returns high immediately (async); any pending byte is discarded.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: adds state PARITY between DATA and STOP. uart_txd = XOR of the 8 data bits (even parity) for BPS_CNT cycles. Frame is 8E1/8E2, 11 or 12 bits.
- Undefined: PARITY state and logic absent; frame is 8N1/8N2, 10 or 11 bits.

Test Plan:
- CLK_FREQ=160, UART_BPS=10 (BPS_CNT=16): after reset release, idle 50 cycles -> uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
- Send 0xA5 -> line low 16 cycles starting 2 cycles after accept; bits 1,0,1,0,0,1,0,1 at 16 cycles each; high 16; tx_done single pulse at frame cycle 160; tx_busy high exactly 160 cycles.
- Hold tx_valid high with 0x01, 0x80, 0xFF queued -> second accept the cycle after the first load; frames contiguous (stop bit's last cycle followed directly by a start bit); 3 tx_done pulses 160 cycles apart; decoded bytes match.
- STOP_BITS=2, send 0x00 -> stop high 32 cycles, frame 176 cycles; tx_ready=0 only while byte is held.
- Assert sys_rst during DATA bit 4 of 0x3C with a second byte held -> uart_txd=1 the same cycle; after release no frame is sent, tx_ready=1.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after bit 7; send 0x03 -> parity bit 0; frame 176 cycles.

Source files
------------

// File: rtl/uart_send.sv
// ---------------------------------------------------------------------------
// uart_send -- byte-wide UART transmitter.
//
// Purpose:
//   Serialises bytes onto uart_txd, LSB first, as 8N1/8N2 frames. With
//   UART_TX_PARITY_EN defined, an even-parity bit follows the data bits
//   (8E1/8E2). A one-byte holding register lets the next byte be taken while
//   the current frame is still on the line, so frames can run back-to-back.
//
// Configuration macro:
//   UART_TX_PARITY_EN  -- when defined, adds the even-parity bit.
//
// Parameters:
//   CLK_FREQ   sys_clk frequency in Hz
//   UART_BPS   baud rate; CLK_FREQ/UART_BPS = clocks per bit (2..65535)
//   STOP_BITS  1 or 2
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   asynchronous active-high reset
//   tx_valid   in   byte on tx_data is offered
//   tx_data    in   [7:0] byte to transmit
//   tx_ready   out  holding register empty
//   tx_busy    out  a frame is on the line
//   tx_done    out  one-cycle pulse in the last cycle of the final stop bit
//   uart_txd   out  serial line, idle high
//   dbg_state  out  [2:0] current FSM state, for observation only
//
// Handshake: a byte is transferred on a rising edge where tx_valid and
// tx_ready are both 1. tx_data is sampled only on that edge. tx_valid while
// tx_ready is 0 has no effect; the sender keeps its byte until it is taken.
//
// Output timing: every output is a flop fed from the current FSM state, so
// the line lags the state register by one cycle. With an accept on edge N
// the byte is loaded on edge N+1 and the start bit appears after edge N+2.
// ---------------------------------------------------------------------------
module uart_send #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd,
  output logic [2:0] dbg_state
);

  localparam int         BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST = 16'(BPS_CNT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t      state_q,     state_d;
  logic [15:0] baud_cnt_q,  baud_cnt_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_ready_q,  tx_ready_d;
  logic        tx_busy_q,   tx_busy_d;
  logic        tx_done_q,   tx_done_d;
  logic        txd_q,       txd_d;

  logic accept;
  logic load;
  logic baud_last;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q + 16'd1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    accept      = tx_valid & tx_ready_q;
    baud_last   = (baud_cnt_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 3'd0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          // Natural 3-bit wrap leaves the counter at 0 after bit 7.
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          state_d    = S_STOP;
        end
      end
`endif

      S_STOP: begin
        // bit_cnt counts stop bits here; baud counter restarts per stop bit.
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 3'd0;
            if (hold_full_q) begin
              // Next start bit follows the final stop cycle directly.
              load    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 3'd0;
      end
    endcase

    if (load) begin
      shift_d = hold_data_q;
    end

    // accept and load are exclusive: accept needs an empty register,
    // load needs a full one.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end else if (load) begin
      hold_full_d = 1'b0;
    end

    tx_ready_d = ~hold_full_d;

    // Line value for the state currently held in state_q.
    case (state_q)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[bit_cnt_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = ^shift_q;
`endif
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase

    tx_busy_d = (state_q != S_IDLE);
    tx_done_d = (state_q == S_STOP) && baud_last && (bit_cnt_q == STOP_LAST);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= 16'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      hold_data_q <= 8'd0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
      txd_q       <= txd_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;
  assign uart_txd  = txd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_send.sv
// ---------------------------------------------------------------------------
// tb_uart_send -- bench for uart_send.
//
// Two instances share one stimulus stream: index 0 uses one stop bit,
// index 1 uses two. A frame-level model predicts, per instance, the line,
// busy, done and ready values every cycle; a compare process checks them on
// every falling edge. Directed sequences add hand-derived pins on top.
// ---------------------------------------------------------------------------
module tb_uart_send;

  localparam int CLK_FREQ = 160;
  localparam int UART_BPS = 10;
  localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'd0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       ready_w[2];
  logic       busy_w[2];
  logic       done_w[2];
  logic       txd_w[2];
  logic [2:0] dbg_w[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_send #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS),
      .STOP_BITS(g + 1)
    ) u_dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (ready_w[g]),
      .tx_busy  (busy_w[g]),
      .tx_done  (done_w[g]),
      .uart_txd (txd_w[g]),
      .dbg_state(dbg_w[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h",
                  name, idx, cyc, act, exp);
  endtask

  // ---------------- frame-level model ----------------
  function automatic logic [11:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {3'b111, ^d, d, 1'b0};
`else
    return {4'b1111, d, 1'b0};
`endif
  endfunction

  int          pos[2];      // cycle index inside the frame, -1 when idle
  logic [11:0] fbits[2];    // frame bits, bit 0 goes out first
  int          flen[2];     // frame length in bits
  logic        m_full[2];
  logic [7:0]  m_data[2];
  logic        e_txd[2], e_busy[2], e_done[2], e_ready[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pos[i] = -1; m_full[i] = 1'b0; m_data[i] = 8'd0;
        fbits[i] = 12'hfff; flen[i] = 0;
        e_txd[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_ready[i] = 1'b1;
      end else begin
        if (pos[i] >= 0) begin
          e_txd[i]  = fbits[i][pos[i] / BPS];
          e_busy[i] = 1'b1;
          e_done[i] = (pos[i] == flen[i] * BPS - 1);
          pos[i]++;
          if (pos[i] == flen[i] * BPS) pos[i] = -1;
        end else begin
          e_txd[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        end
        if (pos[i] < 0 && m_full[i]) begin
          fbits[i]  = frame_of(m_data[i]);
          flen[i]   = 10 + PAR + i;
          pos[i]    = 0;
          m_full[i] = 1'b0;
        end else if (tx_valid && !m_full[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = tx_data;
        end
        e_ready[i] = !m_full[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        check("txd",   i, txd_w[i],   1'b1);
        check("ready", i, ready_w[i], 1'b1);
        check("busy",  i, busy_w[i],  1'b0);
        check("done",  i, done_w[i],  1'b0);
      end else begin
        check("txd",   i, txd_w[i],   e_txd[i]);
        check("ready", i, ready_w[i], e_ready[i]);
        check("busy",  i, busy_w[i],  e_busy[i]);
        check("done",  i, done_w[i],  e_done[i]);
      end
    end
  end

  int done_times[$];
  always @(negedge clk) if (!rst && done_w[0]) done_times.push_back(cyc);

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int quiet = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy_w[0] && !busy_w[1] && ready_w[0] && ready_w[1]) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    check("idle_timeout_busy", 0, busy_w[0], 1'b0);
  endtask

  // Returns at the falling edge after the accept edge, with tx_valid low.
  task automatic offer(input logic [7:0] b, output int acc);
    int k = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (!ready_w[0] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      check("offer_timeout_ready", 0, ready_w[0], 1'b1);
      tx_valid = 1'b0;
      acc = -1;
      return;
    end
    @(negedge clk);
    acc      = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Sample index e = falling edge after (accept edge + e).
  logic r_txd[2][256], r_busy[2][256], r_done[2][256], r_ready[2][256];

  task automatic record(input int e);
    for (int i = 0; i < 2; i++) begin
      r_txd[i][e] = txd_w[i]; r_busy[i][e] = busy_w[i];
      r_done[i][e] = done_w[i]; r_ready[i][e] = ready_w[i];
    end
  endtask

  task automatic send_and_pin(input logic [7:0] b);
    int acc, len, busy_n, done_n, done_at;
    wait_idle();
    offer(b, acc);
    record(0);
    for (int e = 1; e < 256; e++) begin
      @(negedge clk);
      record(e);
    end
    for (int i = 0; i < 2; i++) begin
      len = (10 + PAR + i) * BPS;
      check("pin_ready_held", i, r_ready[i][0], 1'b0);
      check("pin_ready_free", i, r_ready[i][1], 1'b1);
      check("pin_pre_start",  i, r_txd[i][1],  1'b1);
      check("pin_start_first", i, r_txd[i][2], 1'b0);
      check("pin_start_last", i, r_txd[i][1 + BPS], 1'b0);
      for (int j = 0; j < 8; j++)
        check("pin_data", i * 8 + j, r_txd[i][2 + BPS * (1 + j) + BPS / 2], b[j]);
      for (int s = 0; s <= i; s++)
        check("pin_stop", i * 2 + s, r_txd[i][2 + BPS * (9 + PAR + s) + BPS / 2], 1'b1);
      busy_n = 0; done_n = 0; done_at = -1;
      for (int e = 0; e < 256; e++) begin
        if (r_busy[i][e]) busy_n++;
        if (r_done[i][e]) begin done_n++; done_at = e; end
      end
      check("pin_busy_len", i, busy_n, len);
      check("pin_done_cnt", i, done_n, 1);
      check("pin_done_at",  i, done_at, 1 + len);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a1, a2, a3, lows;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Quiet line after reset.
    repeat (50) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("idle_txd",   i, txd_w[i],   1'b1);
      check("idle_ready", i, ready_w[i], 1'b1);
      check("idle_busy",  i, busy_w[i],  1'b0);
    end

    // Single 0xA5 frame, with hand-derived positions for dut 0.
    send_and_pin(8'hA5);
    check("a5_bit0", 0, r_txd[0][2 + BPS + 8],     1'b1);
    check("a5_bit1", 0, r_txd[0][2 + 2 * BPS + 8], 1'b0);
    check("a5_done", 0, r_done[0][161 + PAR * 16], 1'b1);
    check("a5_busy_end", 0, r_busy[0][162 + PAR * 16], 1'b0);

    // Two-stop-bit instance carrying 0x00.
    send_and_pin(8'h00);
    check("zero_stop2", 1, r_txd[1][2 + BPS * (10 + PAR) + 8], 1'b1);
    check("zero_done2", 1, r_done[1][177 + PAR * 16], 1'b1);

`ifdef UART_TX_PARITY_EN
    send_and_pin(8'h07);
    check("par_07", 0, r_txd[0][2 + BPS * 9 + 8], 1'b1);
    send_and_pin(8'h03);
    check("par_03", 0, r_txd[0][2 + BPS * 9 + 8], 1'b0);
`endif

    // Back-to-back stream.
    wait_idle();
    done_times.delete();
    offer(8'h01, a1);
    offer(8'h80, a2);
    offer(8'hFF, a3);
    wait_idle();
    check("b2b_accept_gap", 0, a2 - a1, 2);
    check("b2b_done_cnt",   0, done_times.size(), 3);
    if (done_times.size() >= 3) begin
      check("b2b_done_gap", 1, done_times[1] - done_times[0], (10 + PAR) * BPS);
      check("b2b_done_gap", 2, done_times[2] - done_times[1], (10 + PAR) * BPS);
    end

    // Reset in the middle of data bit 4 of 0x3C with 0x5A held.
    wait_idle();
    offer(8'h3C, a1);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    for (int e = 1; e <= 90; e++) begin
      @(negedge clk);
      if (e == 2) begin
        tx_valid = 1'b0;
        check("rst_held_ready", 0, ready_w[0], 1'b0);
      end
    end
    check("rst_pre_busy", 0, busy_w[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_async_txd",   i, txd_w[i],   1'b1);
      check("rst_async_ready", i, ready_w[i], 1'b1);
      check("rst_async_busy",  i, busy_w[i],  1'b0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!txd_w[0] || !txd_w[1]) lows++;
    end
    check("rst_no_frame", 0, lows, 0);

    // Randomized traffic with random gaps.
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      offer(8'($urandom_range(0, 255)), a1);
    end
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
